// File: rtl/display_ctrl_pkg.sv
// Encodings shared by the keypad/LCD display path: arbiter state and display modes.
// Also a helper that sizes the cycle counters from their limit.
package display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        MODE_DEC   = 2'd0,
        MODE_HEX   = 2'd1,
        MODE_TEXT  = 2'd2,
        MODE_BLANK = 2'd3
    } disp_mode_e;

    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable up-counter with clear (highest priority), load, enable and terminal count.
// With SATURATE set, the count holds at LIMIT-1 instead of advancing.
module cycle_timer #(
    parameter int WIDTH    = 8,
    parameter int LIMIT    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o = (count_q == TC_VAL);

    always_comb begin
        // NOTE: the default first keeps every path assigned, so no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && !(SATURATE && tc_o)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/display_link_arbiter.sv
// Shares the SPI display driver between two producers: round-robin on ties, one-cycle
// start, watchdog on done, fixed inter-frame gap, and auto-refresh of the last frame.
module display_link_arbiter
    import display_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int REFRESH_CYCLES = 50000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] value0,
    input  logic [15:0] value1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    output logic [1:0]  ack,
    output logic        disp_start,
    output logic [15:0] disp_value,
    output logic [1:0]  disp_mode,
    input  logic        disp_done,
    output logic        busy,
    output logic        timeout_err
);

    localparam int WD_W  = cnt_width(TIMEOUT_CYCLES);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam int REF_W = cnt_width(REFRESH_CYCLES);

    arb_state_e  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        is_refresh_q, is_refresh_d;
    logic        timeout_err_q, timeout_err_d;
    logic        frame_valid_q;
    logic [15:0] disp_value_q;
    logic [1:0]  disp_mode_q;

    logic        latch_en;
    logic        latch_sel;
    logic        issue_entry;
    logic        wd_tc, gap_tc, refresh_pending;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        is_refresh_d  = is_refresh_q;
        timeout_err_d = timeout_err_q;
        latch_en      = 1'b0;
        latch_sel     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester that did not win last time goes first.
                    latch_sel    = (req == 2'b11) ? ~last_grant_q : req[1];
                    latch_en     = 1'b1;
                    last_grant_d = latch_sel;
                    is_refresh_d = 1'b0;
                    state_d      = ISSUE;
                end else if (refresh_pending && frame_valid_q) begin
                    is_refresh_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (disp_done) begin
                    timeout_err_d = 1'b0;
                    state_d       = GAP;
                end else if (wd_tc) begin
                    timeout_err_d = 1'b1;
                    state_d       = GAP;
                end
            end
            GAP: begin
                if (gap_tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue_entry = (state_q == IDLE) && (state_d == ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            is_refresh_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_valid_q <= 1'b0;
            disp_value_q  <= '0;
            disp_mode_q   <= MODE_DEC;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            is_refresh_q  <= is_refresh_d;
            timeout_err_q <= timeout_err_d;
            if (latch_en) begin
                frame_valid_q <= 1'b1;
                disp_value_q  <= latch_sel ? value1 : value0;
                disp_mode_q   <= latch_sel ? mode1  : mode0;
            end
        end
    end

    cycle_timer #(.WIDTH(WD_W), .LIMIT(TIMEOUT_CYCLES), .SATURATE(1'b0)) u_watchdog (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (state_q != WAIT),
        .en_i       (state_q == WAIT),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_o       (wd_tc)
    );

    cycle_timer #(.WIDTH(GAP_W), .LIMIT(GAP_CYCLES), .SATURATE(1'b0)) u_gap (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (state_q != GAP),
        .en_i       (state_q == GAP),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_o       (gap_tc)
    );

    // Idle time is measured from the last issue, so the refresh timer restarts on each one.
    cycle_timer #(.WIDTH(REF_W), .LIMIT(REFRESH_CYCLES), .SATURATE(1'b1)) u_refresh (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (issue_entry),
        .en_i       (1'b1),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tc_o       (refresh_pending)
    );

    assign disp_start  = (state_q == ISSUE);
    assign ack         = (disp_start && !is_refresh_q) ? (last_grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign disp_value  = disp_value_q;
    assign disp_mode   = disp_mode_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_display_link_arbiter.sv
// Directed bench for display_link_arbiter: a scoreboard holds the expected frame for each
// start pulse, and timing points (latency, gap, watchdog, refresh) are checked by cycle.
module tb_display_link_arbiter;

    localparam int TO_C  = 16;
    localparam int REF_C = 32;
    localparam int GAP_C = 4;

    typedef struct {
        logic [1:0]  ack;
        logic [15:0] value;
        logic [1:0]  mode;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] value0 = '0, value1 = '0;
    logic [1:0]  mode0 = '0, mode1 = '0;
    logic [1:0]  ack;
    logic        disp_start;
    logic [15:0] disp_value;
    logic [1:0]  disp_mode;
    logic        disp_done = 1'b0;
    logic        busy;
    logic        timeout_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   last_wait = 0;
    exp_t sb[$];

    display_link_arbiter #(
        .TIMEOUT_CYCLES (TO_C),
        .REFRESH_CYCLES (REF_C),
        .GAP_CYCLES     (GAP_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .value0      (value0),
        .value1      (value1),
        .mode0       (mode0),
        .mode1       (mode1),
        .ack         (ack),
        .disp_start  (disp_start),
        .disp_value  (disp_value),
        .disp_mode   (disp_mode),
        .disp_done   (disp_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ack"},         32'(ack),         32'h0);
        check({tag, " disp_start"},  32'(disp_start),  32'h0);
        check({tag, " disp_value"},  32'(disp_value),  32'h0);
        check({tag, " disp_mode"},   32'(disp_mode),   32'h0);
        check({tag, " busy"},        32'(busy),        32'h0);
        check({tag, " timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;
        disp_done = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero(tag);
        rst = 1'b1;
    endtask

    // Waits up to budget negedges for disp_start, then compares against the scoreboard head.
    task automatic wait_start(input string tag, input int budget);
        exp_t e;
        last_wait = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            last_wait++;
            if (disp_start) break;
        end
        check({tag, " start"}, 32'(disp_start), 32'h1);
        if (disp_start && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " ack"},   32'(ack),        32'(e.ack));
            check({tag, " value"}, 32'(disp_value), 32'(e.value));
            check({tag, " mode"},  32'(disp_mode),  32'(e.mode));
        end
    endtask

    task automatic pulse_done();
        disp_done = 1'b1;
        @(negedge clk);
        disp_done = 1'b0;
    endtask

    initial begin
        int seen;

        // Reset, then silence: no frame is valid so no refresh may fire.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * REF_C + 8; i++) begin
            @(negedge clk);
            if (disp_start || busy) seen++;
        end
        check("no_refresh_after_reset", 32'(seen), 32'h0);

        // Single request with latency 1 and gap timing on busy.
        value0 = 16'h1234; mode0 = 2'd2; req = 2'b01;
        sb.push_back('{ack: 2'b01, value: 16'h1234, mode: 2'd2});
        wait_start("single", 1);
        req = 2'b00;
        repeat (5) @(negedge clk);
        check("single wait busy", 32'(busy), 32'h1);
        pulse_done();
        repeat (GAP_C - 1) @(negedge clk);
        check("single gap busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("single idle busy", 32'(busy), 32'h0);
        check("single value held", 32'(disp_value), 32'h1234);

        // Tie with both held: grants 0, 1, 0 from reset.
        do_reset("reset2");
        value0 = 16'hAAAA; mode0 = 2'd1; value1 = 16'h5555; mode1 = 2'd3; req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) sb.push_back('{ack: 2'b10, value: 16'h5555, mode: 2'd3});
            else        sb.push_back('{ack: 2'b01, value: 16'hAAAA, mode: 2'd1});
            wait_start($sformatf("tie%0d", k), 20);
            if (k == 2) req = 2'b00;
            repeat (2) @(negedge clk);
            pulse_done();
        end
        repeat (GAP_C + 2) @(negedge clk);
        check("tie idle busy", 32'(busy), 32'h0);

        // Watchdog: no done, flag rises 16 cycles after WAIT entry; next done clears it.
        do_reset("reset3");
        value0 = 16'h0F0F; mode0 = 2'd0; req = 2'b01;
        sb.push_back('{ack: 2'b01, value: 16'h0F0F, mode: 2'd0});
        wait_start("wd", 1);
        req = 2'b00;
        repeat (TO_C) @(negedge clk);
        check("wd before limit", 32'(timeout_err), 32'h0);
        @(negedge clk);
        check("wd at limit", 32'(timeout_err), 32'h1);
        check("wd gap busy", 32'(busy), 32'h1);
        value1 = 16'h7777; mode1 = 2'd1; req = 2'b10;
        sb.push_back('{ack: 2'b10, value: 16'h7777, mode: 2'd1});
        wait_start("wd next", 20);
        check("wd next gap latency", 32'(last_wait), 32'(GAP_C + 1));
        req = 2'b00;
        check("wd sticky", 32'(timeout_err), 32'h1);
        repeat (2) @(negedge clk);
        pulse_done();
        check("wd cleared", 32'(timeout_err), 32'h0);

        // Refresh of the held frame with no ack, then req wins the refresh cycle.
        do_reset("reset4");
        value0 = 16'hBEEF; mode0 = 2'd3; req = 2'b01;
        sb.push_back('{ack: 2'b01, value: 16'hBEEF, mode: 2'd3});
        wait_start("beef", 1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        pulse_done();
        sb.push_back('{ack: 2'b00, value: 16'hBEEF, mode: 2'd3});
        wait_start("refresh", 3 * REF_C);
        check("refresh interval", 32'(last_wait), 32'(REF_C - 3));
        repeat (2) @(negedge clk);
        pulse_done();
        repeat (REF_C - 4) @(negedge clk);
        value1 = 16'hCAFE; mode1 = 2'd2; req = 2'b10;
        sb.push_back('{ack: 2'b10, value: 16'hCAFE, mode: 2'd2});
        wait_start("req_beats_refresh", 1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        pulse_done();
        repeat (GAP_C + 2) @(negedge clk);

        // Mid-frame asynchronous reset, then a stray done after release.
        value0 = 16'h1111; mode0 = 2'd1; req = 2'b01;
        sb.push_back('{ack: 2'b01, value: 16'h1111, mode: 2'd1});
        wait_start("midrst", 1);
        req = 2'b00;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midrst async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_done();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (disp_start || busy) seen++;
            @(negedge clk);
        end
        check("stray done ignored", 32'(seen), 32'h0);
        check("stray done value", 32'(disp_value), 32'h0);
        check("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed time %0t required < 200000", $time);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/display_link_arbiter.md
# display_link_arbiter

Shares the single display driver between two 16-bit value producers (req 0: keypad entry counter, req 1: game/status logic) and keeps the LCD refreshed. It latches a winning request, issues a one-cycle start to the display driver, waits for its done with a watchdog, and enforces an inter-frame gap. When idle for long enough, it re-sends the last frame. It sits between the producers and the SPI display driver in the keypad/LCD top level.

## Interface
- TIMEOUT_CYCLES, 65535: max cycles WAIT holds before abandoning a frame
- REFRESH_CYCLES, 50000: idle cycles since last issue before an auto-refresh
- GAP_CYCLES, 4: mandatory idle cycles after each frame, ≥1
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- req  in  2  per-requester request level; hold high with data stable until ack
- value0 / value1  in  16  frame value per requester
- mode0 / mode1  in  2  display mode per requester
- ack  out  2  one-cycle pulse: request accepted and data latched
- disp_start  out  1  one-cycle start to display driver
- disp_value  out  16  latched frame value, stable from start until next issue
- disp_mode  out  2  latched mode, same stability
- disp_done  in  1  driver completion pulse
- busy  out  1  high whenever state ≠ IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE: choose a source in priority order: pending requests, then refresh.
  - With one request, grant it. With both, grant the index ≠ last_grant.
  - last_grant resets to 1, so req 0 wins the first tie.
- On grant (at the IDLE exit edge):
  - latch value/mode into disp_value/disp_mode;
  - update last_grant;
  - set frame_valid;
  - go to ISSUE.
- Refresh: taken only when no req is high, refresh_pending=1 and frame_valid=1. It re-issues the held disp_value/disp_mode with no ack and no change to last_grant.
- ISSUE: lasts exactly one cycle, with disp_start=1 and ack[granted]=1 (ack=0 for refresh). Then go to WAIT.
- WAIT: clear the watchdog on entry and count each cycle.
  - disp_done=1 → GAP and clear timeout_err.
  - Counter reaches TIMEOUT_CYCLES-1 without done → set timeout_err, go to GAP.
- GAP: count GAP_CYCLES cycles, then IDLE. disp_done is ignored in ISSUE, GAP and IDLE.
- Refresh counter:
  - clears on every ISSUE entry;
  - otherwise increments, saturating at REFRESH_CYCLES-1;
  - refresh_pending = (count == REFRESH_CYCLES-1).
- req still high in the first IDLE cycle after its ack is treated as a new request.
- Counter widths are $clog2(param)+1. There is no wrap: the watchdog terminates at its limit and the refresh counter saturates.

## Timing
- Reset values: state IDLE, ack=0, disp_start=0, disp_value=0, disp_mode=0, busy=0, timeout_err=0, frame_valid=0, last_grant=1, all counters 0.
- Reset asserted mid-frame aborts immediately. An in-flight driver done arriving after release is ignored, because the block is then in IDLE.
- Request latency: req high in IDLE at cycle N → ack and disp_start at N+1.
- Minimum frame period is 1 (ISSUE) + ≥1 (WAIT) + GAP_CYCLES + 1 (IDLE) cycles.
- disp_value/disp_mode change only on the IDLE→ISSUE edge.
- A simultaneous req and refresh_pending always resolves to the req.
- A timeout frame still passes through GAP before the next grant.

## Structure
- Shared package display_ctrl_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, GAP=2'd3);
  - mode constants shared with the keyin counter and display driver.
- One sub-module, cycle_timer: a loadable up-counter with clear, enable and terminal-count output, instantiated three times (watchdog, gap, refresh-saturating variant via parameter).
- The arbiter FSM and data latches live in display_link_arbiter.

## Test plan
- Single request: reset, release, req=2'b01, value0=16'h1234, mode0=2'd2, done 5 cycles after start → ack=2'b01 and disp_start one cycle after req; disp_value=16'h1234; busy falls GAP_CYCLES+1 cycles after done.
- Tie then rotation: req=2'b11 held with value0=16'hAAAA, value1=16'h5555 → grants in order 0,1,0 with acks alternating; disp_value follows each grant.
- Watchdog: TIMEOUT_CYCLES=16, no done → timeout_err=1 sixteen cycles after WAIT entry; next grant proceeds normally; next real done clears timeout_err.
- Refresh: REFRESH_CYCLES=32, one frame of 16'hBEEF then silence → disp_start re-pulses with disp_value=16'hBEEF and ack=0. Immediately after reset, no refresh occurs (frame_valid=0).
- Req beats refresh: raise req1 in the same cycle refresh_pending asserts → ack=2'b10, disp_value=value1.
- Mid-frame reset: assert rst low during WAIT → all outputs 0 asynchronously. A stray disp_done after release causes no state change.
